// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB completer backed by a word-addressed register array.
// Inserts WAIT_STATES pready-low cycles in each access phase.
// Flags misaligned, below-base and out-of-range accesses as errors.
// Optional feature macro: APB_MEM_SLAVE_SLVERR_EN.
//   Defined:   pslverr reports errored accesses alongside pready.
//   Undefined: pslverr is tied low.
// In both builds, errored writes are dropped and errored reads return 0.
module apb_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SLAVE_INDEX = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    DEPTH       = 16,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [7:0]            psel,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic                  penable,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int                    IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH * 4);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    sel_s;
  logic [ADDR_WIDTH-1:0]   offset_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    err_s;
  logic                    setup_s;
  logic                    ready_s;
  logic                    done_s;
  logic                    commit_s;
  logic [IDX_W-1:0]        idx_r;
  logic                    err_r;
  logic                    write_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [DATA_WIDTH-1:0]   prdata_r;
  logic [3:0]              cnt_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  // Select decode via a mask so the whole select bus is consumed
  assign sel_s    = |(psel & (8'd1 << SLAVE_INDEX));
  assign offset_s = paddr - BASE_ADDR;
  assign idx_s    = offset_s[2 +: IDX_W];
  assign err_s    = (paddr[1:0] != 2'b00) | (paddr < BASE_ADDR) | (offset_s >= SPAN);

  assign setup_s  = (state_r == IDLE) & sel_s & ~penable;
  assign ready_s  = (state_r == ACCESS) & (cnt_r == 4'd0);
  assign done_s   = (state_r == ACCESS) & sel_s & penable & ready_s;
  assign commit_s = done_s & write_r & ~err_r;

  assign pready = ready_s;
  assign prdata = prdata_r;
`ifdef APB_MEM_SLAVE_SLVERR_EN
  assign pslverr = ready_s & err_r;
`else
  assign pslverr = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: enter ACCESS on setup; leave on completion or dropped select
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (setup_s) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (!sel_s || done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Wait counter: loaded at setup, counts down to zero during ACCESS
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_r <= 4'd0;
    end else if (setup_s) begin
      cnt_r <= 4'(WAIT_STATES);
    end else if ((state_r == ACCESS) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Setup-phase capture of the request; read data is fetched here too
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      idx_r    <= {IDX_W{1'b0}};
      err_r    <= 1'b0;
      write_r  <= 1'b0;
      wdata_r  <= {DATA_WIDTH{1'b0}};
      prdata_r <= {DATA_WIDTH{1'b0}};
    end else if (setup_s) begin
      idx_r   <= idx_s;
      err_r   <= err_s;
      write_r <= pwrite;
      wdata_r <= pwdata;
      if (!pwrite) begin
        prdata_r <= err_s ? {DATA_WIDTH{1'b0}} : mem_r[idx_s];
      end
    end
  end

  // Storage array: cleared by reset, written only at error-free write completion
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (commit_s) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: two instances share one APB bus.
// u0 answers psel[0] (base 0, no wait states); u1 answers psel[1]
// (base 0x1000, three wait states). Expected read data is queued when
// a read is issued and popped when pready is seen.
module tb_apb_mem_slave;

  localparam logic [31:0] B1 = 32'h0000_1000;
`ifdef APB_MEM_SLAVE_SLVERR_EN
  localparam logic SLV = 1'b1;
`else
  localparam logic SLV = 1'b0;
`endif

  logic        pclk;
  logic        presetn;
  logic [7:0]  psel;
  logic [31:0] paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1;
  logic        pslverr0, pslverr1;

  int checks = 0;
  int errors = 0;
  logic [31:0] rq[$];

  apb_mem_slave #(.SLAVE_INDEX(0), .BASE_ADDR(32'h0000_0000), .DEPTH(16), .WAIT_STATES(0)) u0 (
    .pclk(pclk), .presetn(presetn), .psel(psel), .paddr(paddr), .pwrite(pwrite),
    .penable(penable), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  apb_mem_slave #(.SLAVE_INDEX(1), .BASE_ADDR(B1), .DEPTH(16), .WAIT_STATES(3)) u1 (
    .pclk(pclk), .presetn(presetn), .psel(psel), .paddr(paddr), .pwrite(pwrite),
    .penable(penable), .pwdata(pwdata), .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer to slave s; checks pready on every access cycle
  task automatic xfer(input int s, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rd);
    int waits;
    logic rdy, oth, serr;
    logic [31:0] rd, want;
    waits = (s == 1) ? 3 : 0;
    if (!wr) rq.push_back(exp_rd);
    @(negedge pclk);
    psel = 8'(1 << s); paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    paddr = ~addr; pwdata = ~wdata;
    for (int k = 0; k <= waits; k++) begin
      if (k > 0) @(negedge pclk);
      rdy  = (s == 1) ? pready1 : pready0;
      oth  = (s == 1) ? pready0 : pready1;
      serr = (s == 1) ? pslverr1 : pslverr0;
      rd   = (s == 1) ? prdata1 : prdata0;
      check($sformatf("pready s%0d a%h k%0d", s, addr, k), {31'd0, rdy}, {31'd0, k == waits});
      check($sformatf("other_pready s%0d", s), {31'd0, oth}, 32'd0);
      if (k == waits) begin
        check($sformatf("pslverr s%0d a%h", s, addr), {31'd0, serr}, {31'd0, exp_err & SLV});
        if (!wr) begin
          want = rq.pop_front();
          check($sformatf("prdata s%0d a%h", s, addr), rd, want);
        end
      end else begin
        check($sformatf("pslverr_wait s%0d", s), {31'd0, serr}, 32'd0);
      end
    end
  endtask

  initial begin
    presetn = 1'b0; psel = 8'd0; paddr = 32'd0; pwrite = 1'b0; penable = 1'b0; pwdata = 32'd0;
    @(negedge pclk);
    check("rst_pready0", {31'd0, pready0}, 32'd0);
    check("rst_prdata0", prdata0, 32'd0);
    check("rst_pslverr0", {31'd0, pslverr0}, 32'd0);
    check("rst_pready1", {31'd0, pready1}, 32'd0);
    presetn = 1'b1;

    // Access phase without setup must be ignored
    @(negedge pclk);
    psel = 8'd1; penable = 1'b1; pwrite = 1'b0;
    @(negedge pclk);
    check("no_setup_pready0", {31'd0, pready0}, 32'd0);
    psel = 8'd0; penable = 1'b0;
    @(negedge pclk);
    check("no_setup_idle", {31'd0, pready0}, 32'd0);

    // Basic read, then back-to-back write/read
    xfer(0, 32'h0000_0000, 1'b0, 32'd0, 1'b0, 32'h0000_0000);
    xfer(0, 32'h0000_0008, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0);
    xfer(0, 32'h0000_0008, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF);

    // Wait-state slave
    xfer(1, B1 + 32'd4, 1'b1, 32'h1234_5678, 1'b0, 32'd0);
    xfer(1, B1 + 32'd4, 1'b0, 32'd0, 1'b0, 32'h1234_5678);

    // Error accesses on u0
    xfer(0, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd0);
    xfer(0, 32'h0000_0040, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd0);
    xfer(0, 32'h0000_0008, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF);
    xfer(0, 32'h0000_0040, 1'b0, 32'd0, 1'b1, 32'h0000_0000);
    xfer(0, 32'h0000_0000, 1'b0, 32'd0, 1'b0, 32'h0000_0000);
    xfer(0, 32'h0000_003C, 1'b0, 32'd0, 1'b0, 32'h0000_0000);

    // Below-base write on u1 would alias to the last word if not dropped
    xfer(1, B1 - 32'd4, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd0);
    xfer(1, B1 + 32'd60, 1'b0, 32'd0, 1'b0, 32'h0000_0000);

    // Transfer on the neighbouring select bit leaves u0 untouched
    xfer(1, 32'h0000_0010, 1'b1, 32'hCAFE_F00D, 1'b1, 32'd0);
    xfer(0, 32'h0000_0010, 1'b0, 32'd0, 1'b0, 32'h0000_0000);
    xfer(1, B1 + 32'd4, 1'b0, 32'd0, 1'b0, 32'h1234_5678);

    // Reset during a wait state of a pending write
    @(negedge pclk);
    psel = 8'd2; paddr = B1 + 32'd12; pwrite = 1'b1; pwdata = 32'hA5A5_A5A5; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    check("pre_rst_wait_pready1", {31'd0, pready1}, 32'd0);
    check("pre_rst_prdata1", prdata1, 32'h1234_5678);
    #2 presetn = 1'b0;
    #1;
    check("mid_rst_pready1", {31'd0, pready1}, 32'd0);
    check("mid_rst_prdata1", prdata1, 32'd0);
    check("mid_rst_prdata0", prdata0, 32'd0);
    psel = 8'd0; penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    xfer(1, B1 + 32'd12, 1'b0, 32'd0, 1'b0, 32'h0000_0000);
    xfer(1, B1 + 32'd4, 1'b0, 32'd0, 1'b0, 32'h0000_0000);
    xfer(0, 32'h0000_0008, 1'b0, 32'd0, 1'b0, 32'h0000_0000);
    @(negedge pclk);
    psel = 8'd0; penable = 1'b0;
    @(negedge pclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
